mdio_peripheral: RTL and testbench
==================================

Name: mdio_peripheral

Overview:
- PHY-side MDIO responder that sits directly downstream of the MDIO controller.
- Consumes the controller's MDC, MDIO_OUT and MDIO_OE; drives MDIO_IN back to it.
- Decodes 32-bit frames and turns them into reads/writes on a 32x16 external register-file interface.
- MDC is treated as data, oversampled on the single system clock CLK.

Parameters:
- PHY_ADDR, 5'b00001, this peripheral's PHY address (used only with the optional feature).
- MDC_MIN_DIV, 4, minimum CLK cycles per MDC period the block supports; informational, checked by the bench.

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-low reset
- MDC  input  1  MDIO clock from controller
- MDIO_OE  input  1  controller output enable; MDIO_OUT is valid only while high
- MDIO_OUT  input  1  serial frame bits from controller, MSB first
- MDIO_IN  output  1  serial read data to controller
- MDIO_IN_OE  output  1  high while this block drives MDIO_IN
- ADDR  output  5  register-file address (REGAD field)
- WR_DATA  output  16  write data to register file
- WR_STB  output  1  one-CLK write strobe
- RD_DATA  input  16  register-file read data for ADDR, valid within 1 CLK of an ADDR change
- MDIO_DONE  output  1  one-CLK pulse at end of each completed transaction

Behaviour:
- Reset (RESET=0, async): all outputs 0; state IDLE; counters and shift registers cleared.
- MDC edges: mdc_q registered each CLK; rise = MDC & ~mdc_q; fall = ~MDC & mdc_q.
- Frame format, MSB first: ST[31:30]=01, OP[29:28] (01 write, 10 read), PHYAD[27:23], REGAD[22:18], TA[17:16] (don't-care, driven by controller), DATA[15:0].
- Sampling: MDIO_OUT is shifted in on rise only while MDIO_OE=1; bit_cnt (0..31) increments per sampled bit.
- IDLE: first rise with MDIO_OE=1 samples bit 31 and moves to HEADER.
- HEADER: on the 16th sampled bit, ADDR <= REGAD, registered on the same CLK.
  - ST!=01, or OP not in {01,10} -> ABORT.
  - OP=01 -> WRITE.
  - OP=10 -> READ_LOAD.
- WRITE: samples 16 more bits. On the 32nd bit: WR_DATA <= DATA, WR_STB=1 for exactly 1 CLK, MDIO_DONE=1 on the same CLK, then IDLE.
- READ_LOAD: waits 1 CLK, captures RD_DATA into a 16-bit shift register, sets MDIO_IN_OE=1 with MDIO_IN = bit 15, then READ.
- READ: on each fall, shifts the next bit onto MDIO_IN; bits change on the falling edge so the controller samples them on the rising edge. After the 16th rise in READ: MDIO_IN_OE=0, MDIO_IN=0, MDIO_DONE pulses 1 CLK, then IDLE.
- ABORT: no WR_STB and no MDIO_IN_OE; wait until MDIO_OE=0, then IDLE.
- MDIO_OE falling in HEADER or WRITE before bit 32: discard the frame, go to IDLE, no WR_STB, no MDIO_DONE.
- MDIO_OE=1 during READ: ignored; the peripheral keeps driving.
- ADDR holds its last value between transactions. WR_DATA holds until the next write.
- RESET asserted mid-transaction: immediate return to reset values; MDIO_IN_OE drops asynchronously.
- MDC with no MDIO_OE activity: no state change.

Optional Feature:
- Macro: PHY_ADDR_CHECK_EN.
- Defined: at header completion, PHYAD != PHY_ADDR -> ABORT; the frame is silently ignored (no strobe, no drive, no DONE).
- Undefined: PHYAD is ignored and every well-formed frame is answered.

Decomposition:
- Package mdio_pkg holds:
  - ST_CODE=2'b01, OP_WRITE=2'b01, OP_READ=2'b10
  - FRAME_LEN=32, HDR_LEN=16
  - state enum: IDLE, HEADER, WRITE, READ_LOAD, READ, ABORT
  - field bit-position constants
- One natural sub-module: mdc_edge_detect (the mdc_q register plus rise/fall outputs).

Test Plan:
- Write: frame 0x50883C33 (PHY 1, REG 2, data 0x3C33) -> ADDR=2, WR_DATA=0x3C33, one WR_STB pulse and one MDIO_DONE pulse after bit 32; MDIO_IN_OE stays 0.
- Read: frame header 0x6190 (PHY 3, REG 4) with memory model RD_DATA=0xA5C3 at addr 4 -> ADDR=4, MDIO_IN_OE high for 16 MDC periods, serial bits 1010010111000011 on successive rises, then MDIO_DONE; WR_STB never asserted.
- Bad ST: frame 0x10883C33 (ST=00) -> ABORT; no WR_STB, no MDIO_IN_OE, no MDIO_DONE; the next valid write frame is accepted normally.
- Truncation: drop MDIO_OE after 20 bits of a write frame -> no WR_STB; the next frame decodes correctly from bit 31.
- Reset mid-read: drive RESET=0 during the 8th read bit -> MDIO_IN_OE, MDIO_IN, ADDR, WR_STB and MDIO_DONE go to 0 immediately; after release, a write of 0x50883C33 completes correctly.
- PHY_ADDR_CHECK_EN defined, PHY_ADDR=1: read frame to PHY 3 -> no response. Same frame with PHY 1 -> normal read.

Source files
------------

// File: rtl/mdio_peripheral_pkg.sv
// Shared frame constants, header field positions and FSM state type for the MDIO responder.
package mdio_pkg;

   localparam logic [1:0] ST_CODE  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   localparam int FRAME_LEN = 32;
   localparam int HDR_LEN   = 16;

   // LSB position of each header field within the 32-bit frame
   localparam int ST_LSB    = 30;
   localparam int OP_LSB    = 28;
   localparam int PHYAD_LSB = 23;
   localparam int REGAD_LSB = 18;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      WRITE,
      READ_LOAD,
      READ,
      ABORT
   } mdio_state_e;

endpackage

// File: rtl/mdio_peripheral_if.sv
// MDIO pin bundle between the controller (master) and this PHY-side responder (slave).
interface mdio_peripheral_if;

   logic MDC;
   logic MDIO_OE;
   logic MDIO_OUT;
   logic MDIO_IN;
   logic MDIO_IN_OE;

   modport master (output MDC, MDIO_OE, MDIO_OUT, input MDIO_IN, MDIO_IN_OE);
   modport slave  (input MDC, MDIO_OE, MDIO_OUT, output MDIO_IN, MDIO_IN_OE);

endinterface

// File: rtl/mdio_peripheral_mdc_edge_detect.sv
// Oversamples MDC on the system clock and flags its rising and falling edges.
module mdc_edge_detect (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic mdc,
   output logic rise,
   output logic fall
);

   logic mdc_q;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) mdc_q <= 1'b0;
      else        mdc_q <= mdc;
   end

   assign rise = mdc & ~mdc_q;
   assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// PHY-side MDIO responder: decodes 32-bit frames into register-file reads and writes.
// Define PHY_ADDR_CHECK_EN to ignore frames whose PHYAD differs from PHY_ADDR.
//   state     | meaning
//   IDLE      | waiting for the first sampled bit of a frame
//   HEADER    | collecting ST, OP, PHYAD, REGAD, TA
//   WRITE     | collecting 16 write data bits
//   READ_LOAD | one cycle for RD_DATA to settle on the new ADDR
//   READ      | driving 16 read bits, updated on MDC falling edges
//   ABORT     | rejected frame, waiting for MDIO_OE to drop
module mdio_peripheral
   import mdio_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR    = 5'b00001,
   parameter int         MDC_MIN_DIV = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   mdio_peripheral_if.slave mdio,
   output logic [4:0]       ADDR,
   output logic [15:0]      WR_DATA,
   output logic             WR_STB,
   input  logic [15:0]      RD_DATA,
   output logic             MDIO_DONE
);

   mdio_state_e state_q, state_nxt;
   logic        mdc_rise, mdc_fall, sample;
   logic [15:0] sr_q, frame_word, rd_sr_q;
   logic [4:0]  bit_cnt_q;
   logic [3:0]  rd_cnt_q;
   logic        rd_taken_q, oe_q;
   logic        shift_en, hdr_done, wr_done, rd_load, rd_rise, rd_shift, rd_end;
   logic        phy_ok, hdr_ok, unused_cfg;

   mdc_edge_detect u_mdc_edge (
      .clk_sys (CLK),
      .rst_b   (RESET),
      .mdc     (mdio.MDC),
      .rise    (mdc_rise),
      .fall    (mdc_fall)
   );

   assign sample     = mdc_rise & mdio.MDIO_OE;
   // last 16 bits including the one being sampled now: header at bit 16, data at bit 32
   assign frame_word = {sr_q[14:0], mdio.MDIO_OUT};

`ifdef PHY_ADDR_CHECK_EN
   assign phy_ok     = (frame_word[PHYAD_LSB-HDR_LEN +: 5] == PHY_ADDR);
   assign unused_cfg = (MDC_MIN_DIV < 2);
`else
   assign phy_ok     = 1'b1;
   assign unused_cfg = (^PHY_ADDR) ^ (MDC_MIN_DIV < 2);
`endif

   assign hdr_ok = phy_ok && (frame_word[ST_LSB-HDR_LEN +: 2] == ST_CODE) &&
                   ((frame_word[OP_LSB-HDR_LEN +: 2] == OP_WRITE) ||
                    (frame_word[OP_LSB-HDR_LEN +: 2] == OP_READ));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      shift_en  = 1'b0;
      hdr_done  = 1'b0;
      wr_done   = 1'b0;
      rd_load   = 1'b0;
      rd_rise   = 1'b0;
      rd_shift  = 1'b0;
      rd_end    = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample) begin
               shift_en  = 1'b1;
               state_nxt = HEADER;
            end
         end
         HEADER: begin
            if (!mdio.MDIO_OE) begin
               state_nxt = IDLE;
            end else if (sample) begin
               shift_en = 1'b1;
               if (bit_cnt_q == 5'(HDR_LEN-1)) begin
                  hdr_done = 1'b1;
                  if (!hdr_ok)                                          state_nxt = ABORT;
                  else if (frame_word[OP_LSB-HDR_LEN +: 2] == OP_WRITE) state_nxt = WRITE;
                  else                                                  state_nxt = READ_LOAD;
               end
            end
         end
         WRITE: begin
            if (!mdio.MDIO_OE) begin
               state_nxt = IDLE;
            end else if (sample) begin
               shift_en = 1'b1;
               if (bit_cnt_q == 5'(FRAME_LEN-1)) begin
                  wr_done   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         READ_LOAD: begin
            rd_load   = 1'b1;
            state_nxt = READ;
         end
         READ: begin
            // only advance after the controller has sampled the current bit
            rd_shift = mdc_fall & rd_taken_q;
            rd_rise  = mdc_rise;
            if (mdc_rise && rd_cnt_q == 4'd15) begin
               rd_end    = 1'b1;
               state_nxt = IDLE;
            end
         end
         ABORT: begin
            if (!mdio.MDIO_OE) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         ADDR       <= '0;
         WR_DATA    <= '0;
         WR_STB     <= 1'b0;
         MDIO_DONE  <= 1'b0;
         rd_sr_q    <= '0;
         rd_cnt_q   <= '0;
         rd_taken_q <= 1'b0;
         oe_q       <= 1'b0;
      end else begin
         WR_STB    <= 1'b0;
         MDIO_DONE <= 1'b0;
         if (shift_en) sr_q <= frame_word;
         if (state_nxt == IDLE) bit_cnt_q <= '0;
         else if (shift_en)     bit_cnt_q <= bit_cnt_q + 5'd1;
         if (hdr_done) ADDR <= frame_word[REGAD_LSB-HDR_LEN +: 5];
         if (wr_done) begin
            WR_DATA   <= frame_word;
            WR_STB    <= 1'b1;
            MDIO_DONE <= 1'b1;
         end
         if (rd_load) begin
            rd_sr_q    <= RD_DATA;
            rd_cnt_q   <= '0;
            rd_taken_q <= 1'b0;
            oe_q       <= 1'b1;
         end else if (rd_end) begin
            rd_sr_q   <= '0;
            oe_q      <= 1'b0;
            MDIO_DONE <= 1'b1;
         end else begin
            if (rd_rise) begin
               rd_cnt_q   <= rd_cnt_q + 4'd1;
               rd_taken_q <= 1'b1;
            end
            if (rd_shift) begin
               rd_sr_q    <= {rd_sr_q[14:0], 1'b0};
               rd_taken_q <= 1'b0;
            end
         end
      end
   end

   assign mdio.MDIO_IN    = rd_sr_q[15];
   assign mdio.MDIO_IN_OE = oe_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Self-checking bench for mdio_peripheral: acts as the MDIO controller and models the register file.
module tb_mdio_peripheral;
   import mdio_pkg::*;

   localparam logic [4:0] PHY_ADDR    = 5'b00001;
   localparam int         MDC_MIN_DIV = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [4:0]  ADDR;
   logic [15:0] WR_DATA, RD_DATA;
   logic        WR_STB, MDIO_DONE;

   logic [15:0] mem [32];
   int          n_vec = 0;
   int          n_err = 0;
   int          mdc_half = 2;
   logic        oe_allowed = 1'b0;
   logic        stb_prev = 1'b0;
   logic        done_prev = 1'b0;
   logic [20:0] exp_wr [$];
   logic        exp_done [$];
   logic [15:0] exp_rd [$];

   mdio_peripheral_if mdio ();

   mdio_peripheral #(.PHY_ADDR(PHY_ADDR), .MDC_MIN_DIV(MDC_MIN_DIV)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .mdio      (mdio),
      .ADDR      (ADDR),
      .WR_DATA   (WR_DATA),
      .WR_STB    (WR_STB),
      .RD_DATA   (RD_DATA),
      .MDIO_DONE (MDIO_DONE)
   );

   always #5 CLK = ~CLK;

   assign RD_DATA = mem[ADDR];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_frame(input logic [1:0] st, input logic [1:0] op,
                                            input logic [4:0] phy, input logic [4:0] regad,
                                            input logic [15:0] data);
      return {st, op, phy, regad, 2'b10, data};
   endfunction

   function automatic logic phy_answers(input logic [4:0] phy);
      logic ans;
      ans = (phy == PHY_ADDR);
`ifndef PHY_ADDR_CHECK_EN
      ans = 1'b1;
`endif
      return ans;
   endfunction

   // one MDC period: data set while MDC low, controller samples MDIO_IN as it raises MDC
   task automatic send_bit(input logic b, input logic oe, output logic in_s, output logic oe_s);
      mdio.MDC      = 1'b0;
      mdio.MDIO_OUT = b;
      mdio.MDIO_OE  = oe;
      repeat (mdc_half) @(negedge CLK);
      in_s     = mdio.MDIO_IN;
      oe_s     = mdio.MDIO_IN_OE;
      mdio.MDC = 1'b1;
      repeat (mdc_half) @(negedge CLK);
   endtask

   task automatic idle(input int n, input logic toggle);
      mdio.MDIO_OE  = 1'b0;
      mdio.MDIO_OUT = 1'b0;
      mdio.MDC      = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (toggle) mdio.MDC = ~mdio.MDC;
      end
      mdio.MDC = 1'b0;
      @(negedge CLK);
   endtask

   task automatic send_write(input logic [31:0] f, input int nbits, input logic ok);
      logic in_s, oe_s;
      if (ok) begin
         exp_wr.push_back({f[22:18], f[15:0]});
         exp_done.push_back(1'b1);
      end
      for (int i = 31; i > 31 - nbits; i--) send_bit(f[i], 1'b1, in_s, oe_s);
      idle(4, 1'b0);
      if (ok) check_val("wr_addr_hold", 32'(ADDR), 32'(f[22:18]));
   endtask

   task automatic do_read(input logic [15:0] hdr, input int rst_at);
      logic        in_s, oe_s, oe_all, oe_any, ans;
      logic [15:0] got;
      ans = phy_answers(hdr[11:7]);
      if (ans && rst_at > 15) begin
         exp_rd.push_back(mem[hdr[6:2]]);
         exp_done.push_back(1'b0);
      end
      oe_allowed = ans;
      for (int i = 15; i >= 0; i--) send_bit(hdr[i], 1'b1, in_s, oe_s);
      got    = '0;
      oe_all = 1'b1;
      oe_any = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == rst_at) begin
            mdio.MDC     = 1'b0;
            mdio.MDIO_OE = 1'b0;
            repeat (mdc_half) @(negedge CLK);
            check_val("rst_pre_oe", 32'(mdio.MDIO_IN_OE), 32'd1);
            RESET = 1'b0;
            #1;
            check_val("rst_async_outs",
                      32'({mdio.MDIO_IN_OE, mdio.MDIO_IN, ADDR, WR_STB, MDIO_DONE}), 32'd0);
            repeat (3) @(negedge CLK);
            RESET = 1'b1;
            break;
         end
         send_bit(1'b0, 1'b0, in_s, oe_s);
         got    = {got[14:0], in_s};
         oe_all = oe_all & oe_s;
         oe_any = oe_any | oe_s;
      end
      idle(4, 1'b0);
      oe_allowed = 1'b0;
      if (rst_at > 15) begin
         if (ans) begin
            check_val("rd_oe", 32'(oe_all), 32'd1);
            check_val("rd_data", 32'(got), 32'(exp_rd.pop_front()));
         end else begin
            check_val("rd_silent", 32'(oe_any), 32'd0);
         end
         check_val("rd_addr", 32'(ADDR), 32'(hdr[6:2]));
      end
   endtask

   // DUT-side monitor: pops the scoreboard whenever a strobe or done pulse appears
   always @(posedge CLK) begin
      logic [20:0] e;
      #1;
      if (WR_STB) begin
         check_val("wr_stb_len", 32'(stb_prev), 32'd0);
         if (exp_wr.size() == 0) begin
            check_val("wr_unexpected", 32'(WR_STB), 32'd0);
         end else begin
            e = exp_wr.pop_front();
            check_val("wr_addr", 32'(ADDR), 32'(e[20:16]));
            check_val("wr_data", 32'(WR_DATA), 32'(e[15:0]));
         end
      end
      if (MDIO_DONE) begin
         check_val("done_len", 32'(done_prev), 32'd0);
         if (exp_done.size() == 0) check_val("done_unexpected", 32'(MDIO_DONE), 32'd0);
         else                      check_val("done_kind", 32'(WR_STB), 32'(exp_done.pop_front()));
      end
      if (mdio.MDIO_IN_OE && !oe_allowed) check_val("oe_unexpected", 32'(mdio.MDIO_IN_OE), 32'd0);
      stb_prev  = WR_STB;
      done_prev = MDIO_DONE;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no end of test, expected end within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int a = 0; a < 32; a++) mem[a] = 16'($urandom);
      mem[4]        = 16'hA5C3;
      mem[0]        = 16'h8001;
      RESET         = 1'b0;
      mdio.MDC      = 1'b0;
      mdio.MDIO_OE  = 1'b0;
      mdio.MDIO_OUT = 1'b0;
      repeat (3) @(negedge CLK);
      check_val("reset_outs",
                32'({ADDR, WR_DATA, WR_STB, MDIO_DONE, mdio.MDIO_IN, mdio.MDIO_IN_OE}), 32'd0);
      RESET = 1'b1;

      idle(16, 1'b1);
      check_val("mdc_only_addr", 32'(ADDR), 32'd0);

      mdc_half = MDC_MIN_DIV / 2;
      send_write(32'h50883C33, 32, 1'b1);
      check_val("wr1_data", 32'(WR_DATA), 32'h3C33);
      do_read(16'h6190, 99);

      send_write(32'h10883C33, 32, 1'b0);
      send_write(mk_frame(ST_CODE, OP_WRITE, 5'd1, 5'd7, 16'hBEEF), 32, 1'b1);
      check_val("after_bad_st", 32'(WR_DATA), 32'hBEEF);
      send_write(mk_frame(ST_CODE, 2'b11, 5'd1, 5'd9, 16'h1111), 32, 1'b0);
      send_write(mk_frame(ST_CODE, OP_WRITE, 5'd1, 5'd31, 16'hFFFF), 32, 1'b1);
      send_write(mk_frame(ST_CODE, OP_WRITE, 5'd1, 5'd5, 16'h0F0F), 20, 1'b0);
      check_val("trunc_hold", 32'(WR_DATA), 32'hFFFF);
      send_write(mk_frame(ST_CODE, OP_WRITE, 5'd1, 5'd0, 16'h0000), 32, 1'b1);
      check_val("after_trunc", 32'(WR_DATA), 32'h0000);

      mdc_half = 4;
      do_read({ST_CODE, OP_READ, 5'd1, 5'd9, 2'b00}, 99);
      do_read({ST_CODE, OP_READ, 5'd1, 5'd0, 2'b00}, 99);
      do_read(16'h6090, 7);
      send_write(32'h50883C33, 32, 1'b1);
      check_val("post_rst_data", 32'(WR_DATA), 32'h3C33);

      do_read(16'h6190, 99);
      do_read(16'h6090, 99);

      check_val("wr_pending", 32'(exp_wr.size()), 32'd0);
      check_val("done_pending", 32'(exp_done.size()), 32'd0);
      check_val("rd_pending", 32'(exp_rd.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
